// File: rtl/scan138_pkg.sv
// Shared types and constants for the 74LS138 scan sequencer.
package scan138_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Decoder enable triplet ordered {G, G2A, G2B}.
  localparam logic [2:0] DEC_OFF = 3'b011;
  localparam logic [2:0] DEC_ON  = 3'b100;

  // Legal blanking lengths; the gap must be at least one cycle and fit the counter.
  localparam int BLANK_MIN = 1;
  localparam int BLANK_MAX = 255;

  function automatic bit blank_cyc_ok(input int n);
    return (n >= BLANK_MIN) && (n <= BLANK_MAX);
  endfunction

endpackage

// File: rtl/scan_seq_138_next_chan.sv
// Circular search for the next enabled channel in an 8-bit mask.
// With first=1 the lowest set bit is returned; otherwise the search starts
// strictly after cur and wraps, landing on cur itself for a one-hot mask.
module next_chan (
  input  logic [7:0] mask,
  input  logic [2:0] cur,
  input  logic       first,
  output logic [2:0] nxt,
  output logic       wrap,
  output logic       none
);

  logic [2:0] start;
  logic [2:0] idx;
  logic       found;

  // Scan eight positions after the start point; the first hit wins.
  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    start = first ? 3'd7 : cur;
    idx   = '0;
    nxt   = cur;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = start + 3'(k);
      if (!found && mask[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
    none = ~found;
    wrap = found && !first && (nxt <= cur);
  end

endmodule

// File: rtl/scan_seq_138.sv
// Scan sequencer driving the select and enable pins of a 74LS138 decoder.
// Dwells on each enabled channel, then blanks the decoder before moving on.
module scan_seq_138
  import scan138_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             step,
  input  logic [7:0]       mask,
  input  logic [DIV_W-1:0] div,
  output logic             C,
  output logic             B,
  output logic             A,
  output logic             G,
  output logic             G2A,
  output logic             G2B,
  output logic             frame_done,
  output logic             busy
);

  // One counter serves both dwell and blank; it must hold div and BLANK_CYC-1.
  localparam int CNT_W = (DIV_W > 8) ? DIV_W : 8;

  if (!blank_cyc_ok(BLANK_CYC)) begin : g_bad_blank
    $error("scan_seq_138: BLANK_CYC out of range 1..255");
  end

  state_t           state_q, state_d;
  logic [2:0]       addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [2:0]       dec_q, dec_d;
  logic             fd_q, fd_d;
  logic             busy_q, busy_d;

  logic [2:0]       nxt;
  logic             wrap;
  logic             none;
  logic             in_idle;

  assign in_idle = (state_q == IDLE);

  next_chan u_next_chan (
    .mask  (mask),
    .cur   (addr_q),
    .first (in_idle),
    .nxt   (nxt),
    .wrap  (wrap),
    .none  (none)
  );

  // Next-state, counter and output decode for the IDLE/DWELL/BLANK sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    fd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if ((en || step) && !none) begin
          state_d = DWELL;
          addr_d  = nxt;
          cnt_d   = CNT_W'(div);
          run_d   = en;
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = BLANK;
          cnt_d   = CNT_W'(BLANK_CYC - 1);
          if (!none) begin
            addr_d = nxt;
            fd_d   = wrap;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BLANK: begin
        if (cnt_q == '0) begin
          if (run_q && en && (mask != 8'h00)) begin
            state_d = DWELL;
            cnt_d   = CNT_W'(div);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    dec_d  = (state_d == DWELL) ? DEC_ON : DEC_OFF;
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset disables the decoder immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      dec_q   <= DEC_OFF;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      dec_q   <= dec_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign {C, B, A}       = addr_q;
  assign {G, G2A, G2B}   = dec_q;
  assign frame_done      = fd_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_scan_seq_138.sv
// Directed bench for scan_seq_138 (DIV_W=16, BLANK_CYC=2).
module tb_scan_seq_138;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, step;
  logic [7:0]  mask;
  logic [15:0] div;
  logic        C, B, A, G, G2A, G2B, frame_done, busy;

  int checks = 0;
  int errors = 0;

  scan_seq_138 #(.DIV_W(16), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .step       (step),
    .mask       (mask),
    .div        (div),
    .C          (C),
    .B          (B),
    .A          (A),
    .G          (G),
    .G2A        (G2A),
    .G2B        (G2B),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] obs;
  assign obs = {busy, frame_done, G, G2A, G2B, C, B, A};

  // Expected observation word: decoder on means G=1, G2A=G2B=0.
  function automatic logic [7:0] eo(input bit bsy, input bit fd, input bit on, input logic [2:0] a);
    return {bsy, fd, on, ~on, ~on, a};
  endfunction

  typedef struct {
    logic        en;
    logic        step;
    logic [7:0]  mask;
    logic [15:0] div;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] seq_exp [7];
    logic [7:0] e;
    logic [2:0] ch;
    logic       prev_g;
    int         rise_n, run_len, next_fd, w, bad;

    rst_n = 1'b0; en = 1'b0; step = 1'b0; mask = 8'h00; div = 16'd0;

    // Sparse mask, div=0: sequence 2,5,7,2 with frame_done on 7->2, then en drops.
    tbl[0]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 1, 3'd2)};
    tbl[1]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 0, 3'd5)};
    tbl[2]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 0, 3'd5)};
    tbl[3]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 1, 3'd5)};
    tbl[4]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 0, 3'd7)};
    tbl[5]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 0, 3'd7)};
    tbl[6]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 1, 3'd7)};
    tbl[7]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 1, 0, 3'd2)};
    tbl[8]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 0, 3'd2)};
    tbl[9]  = '{1'b1, 1'b0, 8'hA4, 16'd0, eo(1, 0, 1, 3'd2)};
    tbl[10] = '{1'b0, 1'b0, 8'hA4, 16'd0, eo(1, 0, 0, 3'd5)};
    tbl[11] = '{1'b0, 1'b0, 8'hA4, 16'd0, eo(1, 0, 0, 3'd5)};
    tbl[12] = '{1'b0, 1'b0, 8'hA4, 16'd0, eo(0, 0, 0, 3'd5)};
    tbl[13] = '{1'b0, 1'b0, 8'hA4, 16'd0, eo(0, 0, 0, 3'd5)};

    repeat (2) @(posedge clk);
    #3;
    check("reset_state", obs, eo(0, 0, 0, 3'd0));
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; step = tbl[i].step; mask = tbl[i].mask; div = tbl[i].div;
      tick();
      check($sformatf("vec%0d", i), obs, tbl[i].exp);
    end

    // Empty mask: requests are ignored and the decoder stays off.
    mask = 8'h00; en = 1'b1; step = 1'b1; div = 16'd3;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy || G || !G2A || !G2B) bad++;
    end
    check("mask0_idle", bad, 0);
    en = 1'b0; step = 1'b0;

    // Single step on channel 4, div=2; a second step while busy is ignored.
    seq_exp[0] = eo(1, 0, 1, 3'd4);
    seq_exp[1] = eo(1, 0, 1, 3'd4);
    seq_exp[2] = eo(1, 0, 1, 3'd4);
    seq_exp[3] = eo(1, 1, 0, 3'd4);
    seq_exp[4] = eo(1, 0, 0, 3'd4);
    seq_exp[5] = eo(0, 0, 0, 3'd4);
    seq_exp[6] = eo(0, 0, 0, 3'd4);
    mask = 8'h10; div = 16'd2;
    for (int t = 0; t < 7; t++) begin
      step = (t == 0 || t == 2);
      tick();
      check($sformatf("step_t%0d", t), obs, seq_exp[t]);
    end
    step = 1'b0;

    // Full mask, div=3: 6-cycle channel period, frame_done every 48 cycles.
    mask = 8'hFF; div = 16'd3; en = 1'b1;
    prev_g = 1'b0; rise_n = 0; run_len = 0; next_fd = 47;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (G && !prev_g) begin
        ch = 3'(rise_n % 8);
        check("run_order", {C, B, A}, ch);
        rise_n++;
        run_len = 0;
      end
      if (G) run_len++;
      if (!G && prev_g) check("run_dwell_len", run_len, 4);
      if (frame_done) begin
        check("run_frame_at", c, next_fd);
        next_fd += 48;
      end
      prev_g = G;
    end
    check("run_frame_count", next_fd, 47 + 96);
    en = 1'b0;
    w = 0;
    while (busy && w < 20) begin
      tick();
      w++;
    end
    check("run_stop_busy", busy, 0);

    // en drops mid-dwell on channel 3: dwell completes, blank, idle on 4.
    mask = 8'h18; div = 16'd5; en = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      if (t == 3) en = 1'b0;
      tick();
      e = (t <= 6) ? eo(1, 0, 1, 3'd3) : (t <= 8) ? eo(1, 0, 0, 3'd4) : eo(0, 0, 0, 3'd4);
      check($sformatf("endrop_t%0d", t), obs, e);
    end

    // Mask cleared mid-dwell: addr holds, no frame_done, back to idle.
    mask = 8'h08; div = 16'd5; en = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      if (t == 3) mask = 8'h00;
      tick();
      e = (t <= 6) ? eo(1, 0, 1, 3'd3) : (t <= 8) ? eo(1, 0, 0, 3'd3) : eo(0, 0, 0, 3'd3);
      check($sformatf("mask0drop_t%0d", t), obs, e);
    end

    // Asynchronous reset in the middle of a long dwell on channel 6.
    mask = 8'h40; div = 16'd100; en = 1'b1;
    repeat (3) tick();
    check("pre_reset_dwell", obs, eo(1, 0, 1, 3'd6));
    #2 rst_n = 1'b0;
    #1 check("async_reset", obs, eo(0, 0, 0, 3'd0));
    tick();
    check("reset_held", obs, eo(0, 0, 0, 3'd0));
    mask = 8'h42;
    #2 rst_n = 1'b1;
    tick();
    check("restart_lowest", obs, eo(1, 0, 1, 3'd1));
    tick();
    check("restart_dwell", obs, eo(1, 0, 1, 3'd1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_seq_138.md
# scan_seq_138

Scan sequencer that drives the select (C, B, A) and enable (G, G2A, G2B) inputs of the D_74LS138 3-to-8 decoder. It steps through the enabled channels of an 8-bit mask with a programmable dwell time. Between channels it inserts a blanking gap with the decoder disabled, so the decoder's active-low Y outputs never glitch onto the wrong line. It sits directly upstream of D_74LS138 in the display/scan path.

## Interface
- DIV_W, 16, width of dwell-count input
- BLANK_CYC, 2, blanking cycles between channels (legal range 1..255)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; one clock; asynchronous, active-low
- en  in  1  continuous-scan request (level)
- step  in  1  single-channel request (pulse), honoured only in IDLE with en=0
- mask  in  8  channel enable; bit i=1 → channel i is scanned
- div  in  DIV_W  dwell length minus 1, in clk cycles
- C, B, A  out  1 each  decoder select, {C,B,A} = channel index
- G  out  1  decoder enable (active-high)
- G2A, G2B  out  1 each  decoder enables (active-low)
- frame_done  out  1  one-cycle pulse on scan wrap-around
- busy  out  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, DWELL, BLANK. All outputs are registered.
- Decoder enabled ⇔ state=DWELL: G=1, G2A=0, G2B=0. Otherwise G=0, G2A=1, G2B=1, so all Y lines are high.
- IDLE → DWELL when (en=1 or step=1) and mask≠0.
  - addr := lowest set bit of mask.
  - dwell counter := latched div.
  - The latched mode is run if en=1, single if en=0.
- IDLE with mask=0: stay IDLE, ignore en/step.
- DWELL: count down. On count=0, go to BLANK.
  - addr := next set mask bit strictly after addr, circular (wraps 7→0).
  - blank counter := BLANK_CYC−1.
  - If next index ≤ current index (includes the single-channel mask case), pulse frame_done for the first BLANK cycle.
- BLANK → DWELL (reload div) when the count ends, if mode=run, en=1 and mask≠0. Otherwise BLANK → IDLE.
- addr changes only on DWELL→BLANK, while the decoder is disabled. {C,B,A} holds its value in IDLE.
- mask and en are sampled at DWELL→BLANK and BLANK exit. Mid-dwell changes never truncate a dwell.
- div is sampled only when a dwell starts.
- step while busy: ignored. step and en both high in IDLE: run mode.
- Mask becomes 0 during DWELL: addr is unchanged at BLANK entry, then BLANK → IDLE, no frame_done.

## Timing
- Reset values:
  - state IDLE
  - C=B=A=0
  - G=0, G2A=1, G2B=1
  - frame_done=0, busy=0
- Reset is asynchronous at any point, mid-DWELL included. The decoder is disabled immediately.
- en sampled high at edge k → outputs show DWELL at edge k+1 (one-cycle latency).
- Dwell lasts div+1 cycles. Blank lasts BLANK_CYC cycles.
- In run mode the channel period is div+1+BLANK_CYC cycles.
- A single-step transaction runs div+1+BLANK_CYC cycles, then busy falls.
- frame_done is coincident with the first BLANK cycle.

## Structure
- Package scan138_pkg holds:
  - state enum (IDLE, DWELL, BLANK)
  - decoder-disabled constant {G,G2A,G2B}=3'b011
  - BLANK_CYC range checks
- Sub-module next_chan: combinational circular search. Inputs: mask[7:0], cur[2:0], first. Outputs: nxt[2:0], wrap, none.
- Prescaler counters and the FSM live in the top module.

## Test plan
- mask=8'hFF, div=3, BLANK_CYC=2, en=1 → addr 0..7 each dwells 4 cycles with 2-cycle gaps; frame_done on 7→0 every 48 cycles.
- mask=8'b1010_0100, div=0 → sequence 2,5,7,2…; frame_done on 7→2; Y low only on lines 2, 5, 7 through D_74LS138.
- en=0, mask=8'h10, step pulse → one dwell on channel 4 (div+1 cycles), blank, busy falls, frame_done pulses once.
- mask=0, en=1 → stays IDLE, G=0, G2A=1, busy=0 indefinitely.
- en drops mid-dwell on channel 3 → dwell completes, blank, IDLE. Set mask to 0 mid-dwell → same, with no frame_done.
- rst_n low mid-dwell on channel 6, div=100 → immediate G=0, G2A=1, G2B=1, {C,B,A}=0. After release with en=1, the scan restarts at the lowest mask bit.
